video_frame_reader: RTL and testbench
=====================================

// Module: video_frame_reader
// PURPOSE
//  Read-side counterpart of the CMOS frame writer in video_stiching_top: pops 128-bit frame-buffer words
//  from a first-word-fall-through (FWFT) read FIFO filled by the DDR AXI read master, unpacks them into
//  24-bit pixels and generates the video_vsync/video_hsync/video_de/video_data stream consumed by
//  video_to_pic. Also issues a per-frame request so the read master rewinds to the frame base address.
// PARAMETERS
//  IMG_HDISP   1280  active pixels per line; must be a multiple of PIX_PER_WORD
//  IMG_VDISP   720   active lines per frame
//  H_FRONT     110   horizontal front porch, clocks
//  H_SYNC      40    hsync width, clocks
//  H_BACK      220   horizontal back porch, clocks
//  V_FRONT     5     vertical front porch, lines
//  V_SYNC      5     vsync width, lines
//  V_BACK      20    vertical back porch, lines
//  FIFO_WIDTH  128   read-FIFO word width
//  DATA_WIDTH  24    output pixel width; each pixel occupies a 32-bit lane, bits [23:0] used
//  SYNC_POL    1     1 = syncs active-high, 0 = active-low
// PORTS
//  clk          in   1          video clock (video_clk domain)
//  rst_n        in   1          asynchronous active-low reset
//  en           in   1          run request; sampled as described under BEHAVIOUR
//  fifo_empty   in   1          read FIFO empty
//  fifo_dout    in   FIFO_WIDTH FWFT head word; pixel k = bits [32k+23:32k], k=0 displayed first
//  fifo_rd_en   out  1          pop head word
//  frame_req    out  1          1-cycle pulse: read master restarts at frame base address
//  underflow    out  1          sticky: a pixel slot found the FIFO empty in the current frame
//  video_vsync  out  1          vertical sync
//  video_hsync  out  1          horizontal sync
//  video_de     out  1          active-video qualifier
//  video_data   out  DATA_WIDTH pixel, valid when video_de=1, 0 otherwise
// BEHAVIOUR
//  - Reset: state IDLE, h_cnt=v_cnt=0, lane=0; fifo_rd_en=frame_req=underflow=video_de=0,
//    video_data=0, video_vsync=video_hsync=~SYNC_POL (inactive).
//  - H_TOTAL=IMG_HDISP+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. h_cnt 0..H_TOTAL-1 wraps, incrementing
//    v_cnt (0..V_TOTAL-1, wraps). Order per axis: active, front porch, sync, back porch.
//    hsync active for h_cnt in [IMG_HDISP+H_FRONT, +H_SYNC); vsync active for whole lines v_cnt in
//    [IMG_VDISP+V_FRONT, +V_SYNC). Active = h_cnt<IMG_HDISP && v_cnt<IMG_VDISP.
//  - States: IDLE -> FILL -> RUN -> IDLE.
//    IDLE: counters held at 0, outputs inactive. en=1 -> frame_req pulses one cycle, go FILL.
//    FILL: counters held; when fifo_empty=0 go RUN (first active pixel output 1 clk after entering RUN).
//    RUN: counters free-run. en=0 is honoured only at frame wrap (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1)
//    -> IDLE; otherwise the frame completes.
//  - In RUN, frame_req pulses once per frame on the cycle h_cnt=0, v_cnt=IMG_VDISP+V_FRONT (vsync start).
//  - Unpack: lane=h_cnt[1:0] in active region; pixel = fifo_dout lane slice. fifo_rd_en is combinational
//    = active && lane==3 && !fifo_empty (pop after 4th pixel). Never asserted while fifo_empty=1.
//  - Latency: sync/de/data registered, exactly 1 clk after the corresponding counter value; all three
//    outputs aligned with each other.
//  - Underflow: active slot with fifo_empty=1 -> video_data=0 for that slot, no pop, underflow set;
//    lane still advances (line geometry never stretches). underflow clears on the frame_req cycle.
//  - Asynchronous reset mid-frame returns immediately to reset values; no partial frame resumes.
// TESTING (bench params: HDISP=8, VDISP=2, H_FRONT=2, H_SYNC=2, H_BACK=2, V_FRONT=1, V_SYNC=1, V_BACK=1)
//  1 Reset, en=0, FIFO holding words -> 200 clks: all outputs inactive, fifo_rd_en=0, frame_req=0.
//  2 en=1, FIFO empty 10 clks then 4 words loaded -> one frame_req, state stays FILL until !empty,
//    then video_de high 8 clks per line, exactly 2 pops per line, H_TOTAL=14, V_TOTAL=5.
//  3 Word 0x00000004_00000003_00000002_00000001 -> video_data sequence 1,2,3,4 on consecutive de clks.
//  4 Sync check: hsync active 2 clks starting 10 clks after line's first de; vsync one full line
//    (14 clks) starting line 3; frame_req exactly on vsync's first counter cycle; SYNC_POL=0 inverts.
//  5 FIFO empty during 2nd word of line 1 -> pixels 4..7 output 0, no pop, underflow=1 until next
//    frame_req; following lines stay 14 clks long.
//  6 Drop en mid-frame -> frame completes, IDLE after wrap; assert rst_n=0 mid-line -> outputs to
//    reset values asynchronously, de never glitches high.

Source files
------------

// File: rtl/video_frame_reader.sv
// Frame-buffer read side: unpacks 128-bit FWFT FIFO words into 24-bit pixels
// and generates the vsync/hsync/de/data video timing stream.
module video_frame_reader #(
    parameter int IMG_HDISP  = 1280,
    parameter int IMG_VDISP  = 720,
    parameter int H_FRONT    = 110,
    parameter int H_SYNC     = 40,
    parameter int H_BACK     = 220,
    parameter int V_FRONT    = 5,
    parameter int V_SYNC     = 5,
    parameter int V_BACK     = 20,
    parameter int FIFO_WIDTH = 128,
    parameter int DATA_WIDTH = 24,
    parameter int SYNC_POL   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  frame_req,
    output logic                  underflow,
    output logic                  video_vsync,
    output logic                  video_hsync,
    output logic                  video_de,
    output logic [DATA_WIDTH-1:0] video_data
);

    localparam int H_TOTAL      = IMG_HDISP + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = IMG_VDISP + V_FRONT + V_SYNC + V_BACK;
    localparam int PIX_PER_WORD = FIFO_WIDTH / 32;
    localparam int LANE_W       = $clog2(PIX_PER_WORD);
    localparam int HW           = $clog2(H_TOTAL);
    localparam int VW           = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT    = HW'(IMG_HDISP);
    localparam logic [HW-1:0] H_SYNC_S = HW'(IMG_HDISP + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_L = HW'(IMG_HDISP + H_FRONT + H_SYNC - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(IMG_VDISP);
    localparam logic [VW-1:0] V_SYNC_S = VW'(IMG_VDISP + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_L = VW'(IMG_VDISP + V_FRONT + V_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PIX_PER_WORD - 1);
    localparam logic SYNC_ON = (SYNC_POL != 0);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t              state, state_nxt;
    logic [HW-1:0]       h_cnt, h_nxt;
    logic [VW-1:0]       v_cnt, v_nxt;
    logic [LANE_W-1:0]   lane;
    logic                active, hsync_on, vsync_on;
    logic [DATA_WIDTH-1:0] pixel;

    always_comb begin
        lane     = h_cnt[LANE_W-1:0];
        active   = (state == RUN) && (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hsync_on = (state == RUN) && (h_cnt >= H_SYNC_S) && (h_cnt <= H_SYNC_L);
        vsync_on = (state == RUN) && (v_cnt >= V_SYNC_S) && (v_cnt <= V_SYNC_L);
        pixel    = fifo_dout[32*lane +: DATA_WIDTH];
        // Pop only after the last lane has been shown, and never from an empty FIFO.
        fifo_rd_en = active && (lane == LANE_LAST) && !fifo_empty;
    end

    // Counters only run in RUN; en is honoured only at the frame wrap point.
    always_comb begin
        state_nxt = state;
        h_nxt     = h_cnt;
        v_nxt     = v_cnt;
        frame_req = 1'b0;
        case (state)
            IDLE: begin
                h_nxt = '0;
                v_nxt = '0;
                if (en) begin
                    frame_req = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (!fifo_empty) state_nxt = RUN;
            end
            RUN: begin
                frame_req = (h_cnt == '0) && (v_cnt == V_SYNC_S);
                if (h_cnt == H_LAST) begin
                    h_nxt = '0;
                    v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_nxt = h_cnt + 1'b1;
                end
                if ((h_cnt == H_LAST) && (v_cnt == V_LAST) && !en) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            state <= state_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // Outputs lag the counters by one clock; an empty slot still consumes its lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow   <= 1'b0;
            video_de    <= 1'b0;
            video_data  <= '0;
            video_hsync <= ~SYNC_ON;
            video_vsync <= ~SYNC_ON;
        end else begin
            if (frame_req)
                underflow <= 1'b0;
            else if (active && fifo_empty)
                underflow <= 1'b1;
            video_de    <= active;
            video_data  <= (active && !fifo_empty) ? pixel : '0;
            video_hsync <= hsync_on ? SYNC_ON : ~SYNC_ON;
            video_vsync <= vsync_on ? SYNC_ON : ~SYNC_ON;
        end
    end

endmodule

// File: tb/tb_video_frame_reader.sv
// Bench for video_frame_reader: FIFO model, cycle model with a scoreboard of
// expected video outputs, table of packed words, and hand-written corner sequences.
module tb_video_frame_reader;

    localparam int HD = 8, VD = 2, HF = 2, HS = 2, HB = 2, VF = 1, VS = 1, VB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         fifo_empty = 1'b1;
    logic [127:0] fifo_dout = '0;

    logic        fifo_rd_en, frame_req, underflow, vsync0, hsync0, de0;
    logic [23:0] data0;
    logic        rd_en1, req1, under1, vsync1, hsync1, de1;
    logic [23:0] data1;

    video_frame_reader #(
        .IMG_HDISP(HD), .IMG_VDISP(VD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .FIFO_WIDTH(128), .DATA_WIDTH(24), .SYNC_POL(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .frame_req(frame_req), .underflow(underflow),
        .video_vsync(vsync0), .video_hsync(hsync0), .video_de(de0), .video_data(data0)
    );

    video_frame_reader #(
        .IMG_HDISP(HD), .IMG_VDISP(VD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .FIFO_WIDTH(128), .DATA_WIDTH(24), .SYNC_POL(0)
    ) dut_neg (
        .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(rd_en1), .frame_req(req1), .underflow(under1),
        .video_vsync(vsync1), .video_hsync(hsync1), .video_de(de1), .video_data(data1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0]     word;
        logic [3:0][23:0] px;
    } vec_t;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] data;
    } vid_t;

    vec_t         table_v [8];
    logic [127:0] fifo_q [$];
    logic [23:0]  pix_q [$];
    vid_t         exp_q [$];

    int   tests = 0;
    int   fails = 0;
    int   pop_cnt = 0;
    int   req_cnt = 0;
    logic pop_pending = 1'b0;
    int   m_state = 0;
    int   m_pos = 0;
    logic m_under = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic update_pins();
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? 128'h0 : fifo_q[0];
    endtask

    task automatic push_word(input logic [127:0] w, input logic [3:0][23:0] px);
        fifo_q.push_back(w);
        for (int k = 0; k < 4; k++) pix_q.push_back(px[k]);
        update_pins();
    endtask

    function automatic logic [3:0][23:0] pix_of(input logic [127:0] w);
        logic [3:0][23:0] r;
        for (int k = 0; k < 4; k++) r[k] = w[32*k +: 24];
        return r;
    endfunction

    task automatic push_random(input int n);
        logic [127:0] w;
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            push_word(w, pix_of(w));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic en_v, input int cycles);
        en = en_v;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    // Waits until the DUT's current counter position is (v, h) in RUN.
    task automatic wait_pos(input int v, input int h);
        int n = 0;
        logic hit = 1'b0;
        while (!hit && n < 300) begin
            tick();
            n++;
            hit = (m_state == 2) && (m_pos == v * HT + h);
        end
        checkOutput("wait_pos", {63'd0, hit}, 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_state != 0 && n < 300) begin
            tick();
            n++;
        end
        checkOutput("wait_idle", m_state, 0);
    endtask

    // FIFO model: pops whatever the DUT requested in the previous cycle.
    always @(posedge clk) begin
        #1;
        if (pop_pending && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            update_pins();
        end
        pop_pending = 1'b0;
    end

    // Cycle model and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        vid_t e;
        int   h, v;
        logic act, ereq, erd;
        if (!rst_n) begin
            checkOutput("reset_video", {de0, hsync0, vsync0, hsync1, vsync1, data0},
                        {3'b000, 2'b11, 24'h0});
            checkOutput("reset_ctrl", {fifo_rd_en, frame_req, underflow}, 3'b000);
            m_state = 0;
            m_pos   = 0;
            m_under = 1'b0;
            exp_q.delete();
            exp_q.push_back('0);
            pop_pending = 1'b0;
        end else begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
            end else begin
                e = exp_q.pop_front();
                checkOutput("video", {de0, hsync0, vsync0, hsync1, vsync1, data0},
                            {e.de, e.hs, e.vs, ~e.hs, ~e.vs, e.data});
            end
            h    = m_pos % HT;
            v    = m_pos / HT;
            act  = (m_state == 2) && (h < HD) && (v < VD);
            ereq = ((m_state == 0) && en) || ((m_state == 2) && h == 0 && v == VD + VF);
            erd  = act && (h % 4 == 3) && !fifo_empty;
            checkOutput("ctrl", {fifo_rd_en, frame_req, underflow}, {erd, ereq, m_under});
            e.de   = act;
            e.hs   = (m_state == 2) && (h >= HD + HF) && (h < HD + HF + HS);
            e.vs   = (m_state == 2) && (v >= VD + VF) && (v < VD + VF + VS);
            e.data = 24'h0;
            if (act && !fifo_empty) begin
                if (pix_q.size() > 0) begin
                    e.data = pix_q.pop_front();
                end else begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL pixel_queue: got 0 entries expected 1");
                end
            end
            exp_q.push_back(e);
            if (ereq) m_under = 1'b0;
            else if (act && fifo_empty) m_under = 1'b1;
            case (m_state)
                0: if (en) m_state = 1;
                1: if (!fifo_empty) m_state = 2;
                default: begin
                    if (m_pos == HT * VT - 1 && !en) begin
                        m_state = 0;
                        m_pos   = 0;
                    end else begin
                        m_pos = (m_pos + 1) % (HT * VT);
                    end
                end
            endcase
            pop_pending = fifo_rd_en;
            if (fifo_rd_en) pop_cnt++;
            if (frame_req) req_cnt++;
        end
    end

    initial begin
        table_v[0] = '{word: 128'h00000004_00000003_00000002_00000001,
                       px: {24'h000004, 24'h000003, 24'h000002, 24'h000001}};
        table_v[1] = '{word: 128'hFF0000AA_80FFFFFF_7F123456_01ABCDEF,
                       px: {24'h0000AA, 24'hFFFFFF, 24'h123456, 24'hABCDEF}};
        table_v[2] = '{word: 128'h00800000_00008000_00000080_00000000,
                       px: {24'h800000, 24'h008000, 24'h000080, 24'h000000}};
        table_v[3] = '{word: 128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0,
                       px: {24'h345678, 24'hBCDEF0, 24'h0F0F0F, 24'hF0F0F0}};
        table_v[4] = '{word: 128'hA5A5A5A5_5A5A5A5A_DEADBEEF_CAFEBABE,
                       px: {24'hA5A5A5, 24'h5A5A5A, 24'hADBEEF, 24'hFEBABE}};
        table_v[5] = '{word: 128'hFFFFFFFF_00000000_FFFFFFFF_00000000,
                       px: {24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000}};
        table_v[6] = '{word: 128'h11111111_22222222_33333333_44444444,
                       px: {24'h111111, 24'h222222, 24'h333333, 24'h444444}};
        table_v[7] = '{word: 128'h00C0FFEE_00BADA55_00FACADE_00DECADE,
                       px: {24'hC0FFEE, 24'hBADA55, 24'hFACADE, 24'hDECADE}};

        // Idle with a loaded FIFO: nothing may be requested or popped.
        rst_n = 1'b0;
        applyStimulus(1'b0, 3);
        push_random(4);
        rst_n = 1'b1;
        applyStimulus(1'b0, 200);
        checkOutput("idle_pops", pop_cnt, 0);
        checkOutput("idle_reqs", req_cnt, 0);
        fifo_q.delete();
        pix_q.delete();
        update_pins();

        // Start with an empty FIFO, then feed two frames from the table.
        applyStimulus(1'b1, 10);
        checkOutput("fill_req_once", req_cnt, 1);
        checkOutput("fill_no_de", {63'd0, de0}, 64'd0);
        for (int i = 0; i < 4; i++) push_word(table_v[i].word, table_v[i].px);
        wait_pos(VD + VF, 0);
        checkOutput("frame1_pops", pop_cnt, 4);
        for (int i = 4; i < 8; i++) push_word(table_v[i].word, table_v[i].px);
        wait_pos(VD + VF, 0);
        checkOutput("frame2_pops", pop_cnt, 8);

        // Three words only: the second word of line 1 underflows.
        push_random(3);
        wait_pos(VD, 0);
        checkOutput("underflow_set", {63'd0, underflow}, 64'd1);
        wait_pos(VD + VF, 0);
        checkOutput("underflow_held", {63'd0, underflow}, 64'd1);
        push_random(4);
        tick();
        checkOutput("underflow_clear", {63'd0, underflow}, 64'd0);

        // Dropping en mid-frame lets the frame finish before going idle.
        wait_pos(1, 3);
        en = 1'b0;
        wait_idle();
        applyStimulus(1'b0, 20);
        checkOutput("total_reqs", req_cnt, 5);
        checkOutput("total_pops", pop_cnt, 15);

        // Restart, then reset asynchronously in the middle of an active line.
        push_random(4);
        applyStimulus(1'b1, 1);
        wait_pos(0, 5);
        en    = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset",
                    {de0, hsync0, vsync0, hsync1, vsync1, data0, fifo_rd_en, frame_req, underflow},
                    {3'b000, 2'b11, 24'h0, 3'b000});
        applyStimulus(1'b0, 3);
        rst_n = 1'b1;
        applyStimulus(1'b0, 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
